// File: rtl/falafel_pkg.sv
// Shared types and defaults for the falafel memory-side blocks.
package falafel_pkg;

    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 4;

    typedef struct packed {
        logic              is_write;
        logic              is_cas;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // Reads and CAS return data; plain writes are fire-and-forget.
    function automatic logic is_rpr(input mem_req_t req);
        return req.is_cas | ~req.is_write;
    endfunction

endpackage

// File: rtl/falafel_id_fifo.sv
// Small FIFO of channel IDs for requests awaiting a memory response.
// Head is read combinationally so responses can be routed in the same cycle.
module falafel_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full_reg;
    assign do_pop  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Flags are registered from the next count so consumers see clean state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_id;
    end

    assign head_id = mem_reg[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign count   = count_reg;

endmodule

// File: rtl/falafel_mem_arb.sv
// Round-robin arbiter sharing one memory port among NUM_CH channels, with
// grant locking during stalls and in-order response routing by channel ID.
module falafel_mem_arb #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = falafel_pkg::DATA_W,
    parameter int MAX_OUTST = falafel_pkg::MAX_OUTST,
    localparam int ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_CH-1:0]                   ch_req_val_i,
    output logic [NUM_CH-1:0]                   ch_req_rdy_o,
    input  falafel_pkg::mem_req_t [NUM_CH-1:0]  ch_req_i,
    output logic [NUM_CH-1:0]                   ch_rsp_val_o,
    input  logic [NUM_CH-1:0]                   ch_rsp_rdy_i,
    output logic [DATA_W-1:0]                   ch_rsp_data_o,
    output logic                                mem_req_val_o,
    input  logic                                mem_req_rdy_i,
    output logic                                mem_req_is_write_o,
    output logic                                mem_req_is_cas_o,
    output logic [DATA_W-1:0]                   mem_req_addr_o,
    output logic [DATA_W-1:0]                   mem_req_data_o,
    input  logic                                mem_rsp_val_i,
    output logic                                mem_rsp_rdy_o,
    input  logic [DATA_W-1:0]                   mem_rsp_data_i,
    output logic [CNT_W-1:0]                    outstanding_o
);
    import falafel_pkg::*;

    logic [ID_W-1:0]   rr_ptr_reg;
    logic              lock_reg;
    logic [ID_W-1:0]   lock_id_reg;
    logic [NUM_CH-1:0] elig;
    logic [ID_W:0]     pick;
    logic [ID_W-1:0]   grant;
    logic              grant_val;
    logic              hs;
    mem_req_t          gnt_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ID_W-1:0]   head_id;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [ID_W-1:0]   ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (req[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Response-producing requests wait while the ID FIFO is full.
            assign elig[gi]         = ch_req_val_i[gi] & (~is_rpr(ch_req_i[gi]) | ~fifo_full);
            assign ch_req_rdy_o[gi] = hs & (grant == ID_W'(gi));
            assign ch_rsp_val_o[gi] = mem_rsp_val_i & ~fifo_empty & (head_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        pick      = rr_pick(elig, rr_ptr_reg);
        grant     = pick[ID_W-1:0];
        grant_val = pick[ID_W];
        if (lock_reg) begin
            grant     = lock_id_reg;
            grant_val = elig[lock_id_reg];
        end
        gnt_req = grant_val ? ch_req_i[grant] : '0;
    end

    assign hs                 = grant_val & mem_req_rdy_i;
    assign mem_req_val_o      = grant_val;
    assign mem_req_is_write_o = gnt_req.is_write;
    assign mem_req_is_cas_o   = gnt_req.is_cas;
    assign mem_req_addr_o     = gnt_req.addr;
    assign mem_req_data_o     = gnt_req.data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg  <= '0;
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
        end else if (hs) begin
            rr_ptr_reg <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            lock_reg   <= 1'b0;
        end else if (grant_val) begin
            lock_reg    <= 1'b1;
            lock_id_reg <= grant;
        end
    end

    assign mem_rsp_rdy_o = ~fifo_empty & ch_rsp_rdy_i[head_id];
    assign fifo_pop      = mem_rsp_val_i & mem_rsp_rdy_o;
    assign ch_rsp_data_o = mem_rsp_data_i;

    falafel_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (hs & is_rpr(gnt_req)),
        .push_id (grant),
        .pop     (fifo_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

endmodule

// File: tb/tb_falafel_mem_arb.sv
// Randomised scoreboard bench for falafel_mem_arb with a queue-based reference
// model of arbitration, outstanding IDs and a latency>=1 memory.
`timescale 1ns/1ps
module tb_falafel_mem_arb;
    import falafel_pkg::*;

    localparam int NUM_CH = 4;
    localparam int MAXO   = 4;
    localparam int DW     = DATA_W;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [NUM_CH-1:0]         ch_req_val_i = '0;
    logic [NUM_CH-1:0]         ch_req_rdy_o;
    mem_req_t [NUM_CH-1:0]     ch_req_i = '0;
    logic [NUM_CH-1:0]         ch_rsp_val_o;
    logic [NUM_CH-1:0]         ch_rsp_rdy_i = '0;
    logic [DW-1:0]             ch_rsp_data_o;
    logic                      mem_req_val_o;
    logic                      mem_req_rdy_i = 1'b0;
    logic                      mem_req_is_write_o;
    logic                      mem_req_is_cas_o;
    logic [DW-1:0]             mem_req_addr_o;
    logic [DW-1:0]             mem_req_data_o;
    logic                      mem_rsp_val_i = 1'b0;
    logic                      mem_rsp_rdy_o;
    logic [DW-1:0]             mem_rsp_data_i = '0;
    logic [2:0]                outstanding_o;

    falafel_mem_arb #(.NUM_CH(NUM_CH), .DATA_W(DW), .MAX_OUTST(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch_req_val_i(ch_req_val_i), .ch_req_rdy_o(ch_req_rdy_o), .ch_req_i(ch_req_i),
        .ch_rsp_val_o(ch_rsp_val_o), .ch_rsp_rdy_i(ch_rsp_rdy_i), .ch_rsp_data_o(ch_rsp_data_o),
        .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
        .mem_req_is_write_o(mem_req_is_write_o), .mem_req_is_cas_o(mem_req_is_cas_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_rsp_val_i(mem_rsp_val_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
        .mem_rsp_data_i(mem_rsp_data_i), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int ch; logic [DW-1:0] data; } sb_t;
    typedef struct { logic [DW-1:0] data; int cyc; } mrsp_t;

    sb_t         sb_q[$];      // expected channel responses, in order
    mrsp_t       mem_q[$];     // memory model: pending response data
    int          ids[$];       // reference: channels awaiting a response
    bit [NUM_CH-1:0] pend_val;
    mem_req_t    pend_req [NUM_CH];
    int          m_rr, m_lock_id, cyc;
    bit          m_lock, rsp_en, rsp_rdy_force, rsp_shown;
    int          gen_mode, mem_rdy_force;
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit rpr(input mem_req_t r);
        return r.is_cas || !r.is_write;
    endfunction

    function automatic void model_reset();
        sb_q.delete(); mem_q.delete(); ids.delete();
        pend_val = '0; m_rr = 0; m_lock = 0; m_lock_id = 0; rsp_shown = 0;
    endfunction

    task automatic set_read(input int c, input logic [DW-1:0] addr);
        pend_val[c] = 1'b1;
        pend_req[c] = '0;
        pend_req[c].addr = addr;
    endtask

    // Drive one cycle of inputs, at least 1ns after the rising edge.
    task automatic drive();
        int r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!pend_val[c]) begin
                if (gen_mode == 1) begin
                    set_read(c, DW'(c * 16));
                end else if (gen_mode == 2 && $urandom_range(9) < 4) begin
                    r = $urandom_range(9);
                    pend_req[c].is_write = (r >= 5);
                    pend_req[c].is_cas   = (r >= 8);
                    pend_req[c].addr     = $urandom;
                    pend_req[c].data     = $urandom;
                    pend_val[c] = 1'b1;
                end
            end
            ch_req_val_i[c] = pend_val[c];
            ch_req_i[c]     = pend_val[c] ? pend_req[c] : '0;
            ch_rsp_rdy_i[c] = rsp_rdy_force ? 1'b1 : ($urandom_range(3) != 0);
        end
        mem_req_rdy_i = (mem_rdy_force >= 0) ? mem_rdy_force[0] : ($urandom_range(9) < 7);
        if (!rsp_en) begin
            mem_rsp_val_i = 1'b0;
            rsp_shown = 1'b0;
        end else if (!rsp_shown) begin
            if (mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(9) < 7) begin
                rsp_shown = 1'b1;
                mem_rsp_val_i = 1'b1;
                mem_rsp_data_i = mem_q[0].data;
            end else if (mem_q.size() == 0 && $urandom_range(9) == 0) begin
                mem_rsp_val_i = 1'b1;          // stray response with nothing in flight
                mem_rsp_data_i = $urandom;
            end else begin
                mem_rsp_val_i = 1'b0;
            end
        end
    endtask

    // Compare DUT against the reference for this cycle, then advance the reference.
    task automatic model_step();
        int g, head, c;
        bit full, exp_mrr;
        mem_req_t er;
        logic [DW-1:0] d;
        full = (ids.size() >= MAXO);
        g = -1;
        if (m_lock) g = m_lock_id;
        else begin
            for (int i = 0; i < NUM_CH; i++) begin
                c = (m_rr + i) % NUM_CH;
                if (g < 0 && pend_val[c] && (!rpr(pend_req[c]) || !full)) g = c;
            end
        end
        er = (g >= 0) ? pend_req[g] : '0;
        head = (ids.size() > 0) ? ids[0] : -1;
        exp_mrr = (head >= 0) && ch_rsp_rdy_i[head];
        check("req_val", mem_req_val_o, g >= 0);
        check("req_addr", mem_req_addr_o, er.addr);
        check("req_data", mem_req_data_o, er.data);
        check("req_kind", {mem_req_is_write_o, mem_req_is_cas_o}, {er.is_write, er.is_cas});
        check("ch_req_rdy", ch_req_rdy_o, (g >= 0 && mem_req_rdy_i) ? (1 << g) : 0);
        check("outstanding", outstanding_o, ids.size());
        check("mem_rsp_rdy", mem_rsp_rdy_o, exp_mrr);
        check("ch_rsp_val", ch_rsp_val_o, (mem_rsp_val_i && head >= 0) ? (1 << head) : 0);
        if (g >= 0 && mem_req_rdy_i) begin
            m_rr = (g + 1) % NUM_CH;
            m_lock = 0;
            if (rpr(pend_req[g])) begin
                d = $urandom;
                ids.push_back(g);
                mem_q.push_back('{data: d, cyc: cyc});
                sb_q.push_back('{ch: g, data: d});
            end
            pend_val[g] = 1'b0;
        end else if (g >= 0) begin
            m_lock = 1;
            m_lock_id = g;
        end
        if (mem_rsp_val_i && exp_mrr) begin
            void'(ids.pop_front());
            void'(mem_q.pop_front());
            rsp_shown = 1'b0;
        end
    endtask

    task automatic do_cycle();
        drive();
        @(negedge clk_i);
        model_step();
    endtask

    task automatic next_edge();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        gen_mode = 0; rsp_en = 1; rsp_rdy_force = 1; mem_rdy_force = 1;
        while ((ids.size() > 0 || pend_val != 0) && n < 200) begin
            do_cycle();
            next_edge();
            n++;
        end
        check("drain_bound", n < 200, 1);
        check("sb_empty", sb_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every channel response handshake.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_rsp_val_o[c] && ch_rsp_rdy_i[c]) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rsp_unexpected: ch%0d got 0x%0h, required no response", c, ch_rsp_data_o);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        check("rsp_ch", c, e.ch);
                        check("rsp_data", ch_rsp_data_o, e.data);
                        $display("rsp ch%0d data=0x%08h", c, ch_rsp_data_o);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; gen_mode = 0; mem_rdy_force = 0; rsp_en = 0; rsp_rdy_force = 0;
        model_reset();
        #1;
        check("rst_req_val", mem_req_val_o, 0);
        check("rst_ch_req_rdy", ch_req_rdy_o, 0);
        check("rst_ch_rsp_val", ch_rsp_val_o, 0);
        check("rst_mem_rsp_rdy", mem_rsp_rdy_o, 0);
        check("rst_outst", outstanding_o, 0);
        check("rst_addr", mem_req_addr_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Fairness: all channels reading, memory always ready, no responses.
        gen_mode = 1; mem_rdy_force = 1; rsp_en = 0;
        for (int k = 0; k < 5; k++) begin
            do_cycle();
            if (k < 4) check("fair_grant", ch_req_rdy_o, 1 << k);
            else begin
                check("full_stall_val", mem_req_val_o, 0);
                check("full_outst", outstanding_o, 4);
            end
            next_edge();
        end
        drain();

        // Stall lock: channel 2 held for three cycles while channel 0 waits.
        gen_mode = 0; rsp_en = 0; mem_rdy_force = 0;
        set_read(2, 'h40);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) set_read(0, 'h10);
            if (k == 3) mem_rdy_force = 1;
            do_cycle();
            if (k < 3) begin
                check("stall_addr", mem_req_addr_o, 'h40);
                check("stall_rdy", ch_req_rdy_o, 0);
            end else if (k == 3) check("stall_release", ch_req_rdy_o, 4'b0100);
            else check("after_lock_grant", ch_req_rdy_o, 4'b0001);
            next_edge();
        end
        drain();

        // Random traffic.
        gen_mode = 2; mem_rdy_force = -1; rsp_en = 1; rsp_rdy_force = 0;
        repeat (400) begin
            do_cycle();
            next_edge();
        end
        drain();

        // Reset with three outstanding and channel 3 locked in a stall.
        gen_mode = 0; rsp_en = 0; mem_rdy_force = 1;
        for (int c = 0; c < 3; c++) set_read(c, DW'(32'h100 + c * 16));
        repeat (3) begin
            do_cycle();
            next_edge();
        end
        set_read(3, 'h300);
        mem_rdy_force = 0;
        do_cycle();
        next_edge();
        check("pre_reset_outst", outstanding_o, 3);
        ch_req_val_i = '0; ch_req_i = '0; mem_req_rdy_i = 0; mem_rsp_val_i = 0; ch_rsp_rdy_i = '0;
        rst_ni = 1'b0;
        #1;
        check("arst_outst", outstanding_o, 0);
        check("arst_req_val", mem_req_val_o, 0);
        check("arst_mem_rsp_rdy", mem_rsp_rdy_o, 0);
        check("arst_ch_rsp_val", ch_rsp_val_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        set_read(1, 'h510);
        set_read(3, 'h530);
        mem_rdy_force = 1;
        do_cycle();
        check("post_reset_grant", ch_req_rdy_o, 4'b0010);
        next_edge();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
